// File: rtl/iomem_router_if.sv
// rtl/iomem_router_if.sv - host iomem bus and peripheral slot bus of the router
// The environment (CPU plus peripherals) takes master; the router takes slave.
interface iomem_router_if #(
  parameter int NUM_SLAVES = 4
);
  logic                    iomem_valid;
  logic [3:0]              iomem_wstrb;
  logic [31:0]             iomem_addr;
  logic [31:0]             iomem_wdata;
  logic                    iomem_ready;
  logic [31:0]             iomem_rdata;
  logic [NUM_SLAVES-1:0]   sel_valid;
  logic [3:0]              sel_wstrb;
  logic [7:0]              sel_addr;
  logic [31:0]             sel_wdata;
  logic [NUM_SLAVES-1:0]   sel_ready;
  logic [32*NUM_SLAVES-1:0] sel_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata,
    input  sel_valid, sel_wstrb, sel_addr, sel_wdata,
    output sel_ready, sel_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata,
    output sel_valid, sel_wstrb, sel_addr, sel_wdata,
    input  sel_ready, sel_rdata
  );
endinterface

// File: rtl/iomem_router.sv
// rtl/iomem_router.sv - iomem page decoder and sequencer for up to 8 peripheral slots
// Unresponsive or unmapped accesses complete with ERR_DATA after TIMEOUT_CYCLES.
module iomem_router #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [7:0]  BASE_PAGE      = 8'h03,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          resetn,
  iomem_router_if.slave bus,
  output logic [7:0]    timeout_count
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t                r_state;
  logic [NUM_SLAVES-1:0] r_sel_valid;
  logic [3:0]            r_sel_wstrb;
  logic [7:0]            r_sel_addr;
  logic [31:0]           r_sel_wdata;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic [15:0]           r_cnt;
  logic [7:0]            r_timeout_count;

  logic [7:0]            w_page_off;
  logic [NUM_SLAVES-1:0] w_decode;
  logic [NUM_SLAVES-1:0] w_hit;
  logic [31:0]           w_slot_rdata;
  logic                  w_timeout;

  // Unsigned wrap makes pages below BASE_PAGE land out of range too.
  assign w_page_off = bus.iomem_addr[31:24] - BASE_PAGE;

  always_comb begin
    w_decode = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_page_off == 8'(i)) w_decode[i] = 1'b1;
    end
  end

  assign w_hit     = bus.sel_ready & r_sel_valid;
  assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_slot_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel_valid[i]) w_slot_rdata = bus.sel_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_sel_valid     <= '0;
      r_sel_wstrb     <= '0;
      r_sel_addr      <= '0;
      r_sel_wdata     <= '0;
      r_rdata         <= '0;
      r_ready         <= 1'b0;
      r_cnt           <= '0;
      r_timeout_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (bus.iomem_valid) begin
            r_sel_valid <= w_decode;
            r_sel_wstrb <= bus.iomem_wstrb;
            r_sel_addr  <= bus.iomem_addr[7:0];
            r_sel_wdata <= bus.iomem_wdata;
            r_cnt       <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A real response beats a coincident timeout.
          if (|w_hit) begin
            r_rdata     <= w_slot_rdata;
            r_sel_valid <= '0;
            r_ready     <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_rdata     <= ERR_DATA;
            r_sel_valid <= '0;
            r_ready     <= 1'b1;
            r_state     <= S_RESP;
            if (r_timeout_count != 8'hFF) r_timeout_count <= r_timeout_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready     <= 1'b0;
          r_sel_valid <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.iomem_ready = r_ready;
  assign bus.iomem_rdata = r_rdata;
  assign bus.sel_valid   = r_sel_valid;
  assign bus.sel_wstrb   = r_sel_wstrb;
  assign bus.sel_addr    = r_sel_addr;
  assign bus.sel_wdata   = r_sel_wdata;
  assign timeout_count   = r_timeout_count;

endmodule
